serial_add_sequencer: RTL and testbench
=======================================

# serial_add_sequencer

Bit-serial N-bit adder controller that time-shares a single one-bit structural full adder (`structuralFullAdder`, port order sum, carryout, a, b, carryin) across all bit positions, one bit per clock. Accepts operands on a start strobe, sequences WIDTH adder evaluations with a registered carry, and presents sum, carry-out and signed overflow with a one-cycle done pulse. This block is the first sequential consumer of the team's full-adder cell and the template for later serial ALU paths.

## Interface

- WIDTH, default 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- carryin  input  1  initial carry, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- carryout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation

- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 → load shift regs A_sh←a, B_sh←b, carry reg←carryin, bit counter←0, clear result shift reg; go RUN. start=0 → stay.
- RUN: full adder fed A_sh[0], B_sh[0], carry reg. Each cycle: A_sh, B_sh shift right one; adder sum bit shifted into result shift reg MSB (shift right); carry reg←adder carryout; counter++. When counter==WIDTH-1 (last bit): capture carry-into-MSB (carry reg value this cycle), go DONE.
- Entering DONE: sum←completed result shift reg; carryout←final adder carryout; overflow←carry-into-MSB XOR final carryout. Outputs hold until next transition into DONE or reset.
- DONE: done=1 for exactly this one cycle. start=1 → reload and go RUN (back-to-back); else → IDLE.
- start in RUN ignored; operand inputs not sampled outside accepted start.
- Counter width ceil(log2(WIDTH)); no wrap beyond WIDTH-1.
- Arithmetic: {carryout,sum} = a + b + carryin, modulo 2^(WIDTH+1).
- Reset (rst_n=0 at a rising edge), any state incl. mid-RUN: state←IDLE, busy=0, done=0, sum=0, carryout=0, overflow=0, shift regs/counter/carry cleared. In-flight operation discarded, no done issued.

## Timing

- Reset values: busy 0, done 0, sum 0, carryout 0, overflow 0.
- start accepted at edge E0 → busy high from E0 through edge E(WIDTH); done high in cycle after edge E(WIDTH), i.e. WIDTH+1 cycles from start assertion to done visible, result valid same cycle as done.
- busy and done never high together.
- Back-to-back: start held through DONE → next busy begins the cycle after done; throughput one add per WIDTH+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- WIDTH=8, a=0x00 b=0x00 cin=0, start one cycle → done exactly 9 cycles after start edge, sum=0x00, carryout=0, overflow=0; busy high 8 cycles.
- a=0xFF b=0x01 cin=0 → sum=0x00 carryout=1 overflow=0; a=0x0F b=0x10 cin=1 → sum=0x20 carryout=0 overflow=0.
- a=0x7F b=0x01 → sum=0x80 carryout=0 overflow=1; a=0x80 b=0x80 → sum=0x00 carryout=1 overflow=1.
- Start 0x12+0x34, pulse start again with a=0xFF b=0xFF at cycle 3 of RUN → ignored; result sum=0x46 carryout=0, single done pulse.
- Start 0xAA+0x55, assert rst_n=0 for one edge at cycle 4 of RUN → all outputs 0, state IDLE, no done; new start 0x01+0x02 → sum=0x03 after 9 cycles.
- Hold start high with changing operands each accept (0x01+0x01, then 0xF0+0x0F) → done pulses every 9 cycles, results 0x02 then 0xFF, carryout 0 both; compare against exhaustive random reference model for 1000 vectors.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one structural full-adder cell is reused for every bit position,
// one bit per clock, with a registered carry between bits.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    structuralFullAdder u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carryin  (carry_q)
    );

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            res_sh  <= '0;
            cnt     <= '0;
            carry_q <= carryin;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
            carry_q <= fa_cout;
            if (last_bit) begin
                // carry_q still holds the carry into the MSB during the last bit
                sum      <= {fa_sum, res_sh[WIDTH-1:1]};
                carryout <= fa_cout;
                overflow <= carry_q ^ fa_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// One-bit full adder built from gate primitives.
module structuralFullAdder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);
    logic ab_x, ab_a, c_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (sum, ab_x, carryin);
    and g_a0 (ab_a, a, b);
    and g_a1 (c_a, ab_x, carryin);
    or  g_o0 (carryout, ab_a, c_a);
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed table, hand-written corner sequences and a random sweep against an arithmetic model.
module tb_serial_add_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         carryin;
    logic         busy, done, carryout, overflow;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive operands and raise start at a falling edge.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        @(negedge clk);
        a = va; b = vb; carryin = vc; start = 1'b1;
    endtask

    // Drop start after the accepting edge and count falling edges until done.
    task automatic wait_done(output int cyc, output int bcnt);
        bit got;
        got = 0; cyc = 0; bcnt = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (busy) bcnt++;
            if (busy && done) check("busy_and_done", 1, 0);
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    vec_t         vecs[6];
    int           cyc, bcnt, ndone;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc, rovf;

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 8'h10, 1'b1, 8'h20, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; carryin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", carryout, 0);
        check("reset_ovf", overflow, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(cyc, bcnt);
            check($sformatf("vec%0d_latency", i), cyc, W + 1);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, W);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), carryout, vecs[i].exp_cout);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_hold_sum", i), sum, vecs[i].exp_sum);
        end

        // start pulsed mid-RUN with other operands must be ignored
        launch(8'h12, 8'h34, 1'b0);
        ndone = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (n == 3) begin a = 8'hFF; b = 8'hFF; end
            if (done) begin
                ndone++;
                check("ignore_latency", n, W + 1);
                check("ignore_sum", sum, 8'h46);
                check("ignore_cout", carryout, 0);
            end
        end
        check("ignore_single_done", ndone, 1);

        // synchronous reset mid-RUN discards the add
        launch(8'hAA, 8'h55, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", carryout, 0);
        check("midrst_ovf", overflow, 0);
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst_no_activity", ndone, 0);
        launch(8'h01, 8'h02, 1'b0);
        wait_done(cyc, bcnt);
        check("after_rst_latency", cyc, W + 1);
        check("after_rst_sum", sum, 8'h03);

        // back-to-back: start held through DONE
        launch(8'h01, 8'h01, 1'b0);
        @(negedge clk);
        a = 8'hF0; b = 8'h0F;
        for (int n = 2; n <= W + 1; n++) @(negedge clk);
        check("b2b_first_done", done, 1);
        check("b2b_first_sum", sum, 8'h02);
        check("b2b_first_cout", carryout, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_after_done", busy, 1);
        check("b2b_no_second_pulse", done, 0);
        for (int n = 2; n <= W + 1; n++) @(negedge clk);
        check("b2b_second_done", done, 1);
        check("b2b_second_sum", sum, 8'hFF);
        check("b2b_second_cout", carryout, 0);

        // random sweep against an arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            launch(ra, rb, rc);
            wait_done(cyc, bcnt);
            check($sformatf("rand%0d_%0h_%0h_%0b", i, ra, rb, rc),
                  {cyc[7:0], carryout, overflow, sum}, {8'(W + 1), full[W], rovf, full[W-1:0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
